// File: rtl/register_file_pkg.sv
// Shared constants for the ALU operand register file: function codes and read-select encodings.
package register_file_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned FS_W     = 3;
  localparam int unsigned SEL_W    = 3;

  // Per-register operation applied on the rising edge when enabled
  localparam logic [FS_W-1:0] FS_DEC  = 3'b000;
  localparam logic [FS_W-1:0] FS_INC  = 3'b001;
  localparam logic [FS_W-1:0] FS_LOAD = 3'b010;
  localparam logic [FS_W-1:0] FS_CLR  = 3'b011;
  localparam logic [FS_W-1:0] FS_LDLO = 3'b100;
  localparam logic [FS_W-1:0] FS_WRB0 = 3'b101;
  localparam logic [FS_W-1:0] FS_WRB1 = 3'b110;
  localparam logic [FS_W-1:0] FS_SEXT = 3'b111;

  // Read-port select: general registers first, then scratch registers
  localparam logic [SEL_W-1:0] SEL_R1 = 3'd0;
  localparam logic [SEL_W-1:0] SEL_R2 = 3'd1;
  localparam logic [SEL_W-1:0] SEL_R3 = 3'd2;
  localparam logic [SEL_W-1:0] SEL_R4 = 3'd3;
  localparam logic [SEL_W-1:0] SEL_S1 = 3'd4;
  localparam logic [SEL_W-1:0] SEL_S2 = 3'd5;
  localparam logic [SEL_W-1:0] SEL_S3 = 3'd6;
  localparam logic [SEL_W-1:0] SEL_S4 = 3'd7;

endpackage

// File: rtl/register_file_cell.sv
// One WIDTH-bit counter/loader register driven by the shared FunSel code.
module register_cell
  import register_file_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                E,
  input  logic [FS_W-1:0]     FunSel,
  input  logic [WIDTH-1:0]    I,
  output logic [WIDTH-1:0]    Q
);

  logic [WIDTH-1:0] q_next;

  // Next value for the enabled case; byte writes keep untouched bits
  always_comb begin
    q_next = Q;
    unique case (FunSel)
      FS_DEC:  q_next = Q - WIDTH'(1);
      FS_INC:  q_next = Q + WIDTH'(1);
      FS_LOAD: q_next = I;
      FS_CLR:  q_next = '0;
      FS_LDLO: q_next = WIDTH'(I[7:0]);
      FS_WRB0: q_next[7:0] = I[7:0];
      FS_WRB1: q_next[15:8] = I[7:0];
      FS_SEXT: q_next = WIDTH'($signed(I[15:0]));
      default: q_next = Q;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Q <= '0;
    end else if (E) begin
      Q <= q_next;
    end
  end

endmodule

// File: rtl/register_file.sv
// ALU operand register file: R1..R4 and S1..S4 with two combinational read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   I,
  input  logic [FS_W-1:0]    FunSel,
  input  logic [3:0]         RegSel,
  input  logic [3:0]         ScrSel,
  input  logic [SEL_W-1:0]   OutASel,
  input  logic [SEL_W-1:0]   OutBSel,
  output logic [WIDTH-1:0]   OutA,
  output logic [WIDTH-1:0]   OutB
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] en;

  // Index order matches the read-select encoding: R1..R4 then S1..S4
  assign en = {ScrSel[0], ScrSel[1], ScrSel[2], ScrSel[3],
               RegSel[0], RegSel[1], RegSel[2], RegSel[3]};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    register_cell #(.WIDTH(WIDTH)) u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .E      (en[g]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (regs[g])
    );
  end

  assign OutA = regs[OutASel];
  assign OutB = regs[OutBSel];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table plus reset and multi-select sequences.
module tb_register_file;
  import register_file_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] I;
  logic [2:0]       FunSel;
  logic [3:0]       RegSel;
  logic [3:0]       ScrSel;
  logic [2:0]       OutASel;
  logic [2:0]       OutBSel;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;

  int n_checks = 0;
  int n_fail   = 0;

  register_file #(.WIDTH(WIDTH)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0]       reg_sel;
    logic [3:0]       scr_sel;
    logic [2:0]       fun_sel;
    logic [WIDTH-1:0] data;
    logic [2:0]       a_sel;
    logic [2:0]       b_sel;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] fs,
                       input logic [WIDTH-1:0] d, input logic [2:0] a, input logic [2:0] b);
    @(negedge Clock);
    RegSel = rs; ScrSel = ss; FunSel = fs; I = d; OutASel = a; OutBSel = b;
  endtask

  task automatic idle();
    @(negedge Clock);
    RegSel = 4'b0000; ScrSel = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b1000, 4'b0000, FS_LOAD, 32'hDEADBEEF, SEL_R1, SEL_R2, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{4'b0100, 4'b0000, FS_DEC,  32'h00000000, SEL_R2, SEL_R1, 32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[2]  = '{4'b0100, 4'b0000, FS_INC,  32'h00000000, SEL_R2, SEL_R1, 32'h00000000, 32'hDEADBEEF};
    vecs[3]  = '{4'b0100, 4'b0000, FS_INC,  32'h00000000, SEL_R2, SEL_S4, 32'h00000001, 32'h00000000};
    vecs[4]  = '{4'b0000, 4'b0010, FS_LOAD, 32'h12345678, SEL_S3, SEL_R2, 32'h12345678, 32'h00000001};
    vecs[5]  = '{4'b0000, 4'b0010, FS_WRB1, 32'h000000AB, SEL_S3, SEL_R1, 32'h1234AB78, 32'hDEADBEEF};
    vecs[6]  = '{4'b0000, 4'b0010, FS_WRB0, 32'h000000CD, SEL_S3, SEL_R1, 32'h1234ABCD, 32'hDEADBEEF};
    vecs[7]  = '{4'b0000, 4'b0010, FS_LDLO, 32'hFFFFFFEF, SEL_S3, SEL_S3, 32'h000000EF, 32'h000000EF};
    vecs[8]  = '{4'b0001, 4'b0000, FS_SEXT, 32'h00008001, SEL_R4, SEL_S3, 32'hFFFF8001, 32'h000000EF};
    vecs[9]  = '{4'b0001, 4'b0000, FS_SEXT, 32'hFFFF7FFF, SEL_R4, SEL_R1, 32'h00007FFF, 32'hDEADBEEF};
    vecs[10] = '{4'b0000, 4'b0000, FS_CLR,  32'hFFFFFFFF, SEL_R1, SEL_S3, 32'hDEADBEEF, 32'h000000EF};
    vecs[11] = '{4'b0010, 4'b0000, FS_LOAD, 32'h00000005, SEL_R3, SEL_R4, 32'h00000005, 32'h00007FFF};
    vecs[12] = '{4'b0000, 4'b1000, FS_LOAD, 32'h00000009, SEL_S1, SEL_R3, 32'h00000009, 32'h00000005};
    vecs[13] = '{4'b1000, 4'b0000, FS_CLR,  32'h12345678, SEL_R1, SEL_R4, 32'h00000000, 32'h00007FFF};

    Reset = 1'b0; I = '0; FunSel = FS_LOAD; RegSel = 4'b1111; ScrSel = 4'b1111;
    OutASel = SEL_R1; OutBSel = SEL_S4;
    I = 32'hFFFFFFFF;
    @(posedge Clock); #1;
    check("reset_outa", OutA, 32'h0);
    check("reset_outb", OutB, 32'h0);
    @(negedge Clock);
    Reset = 1'b1; RegSel = 4'b0000; ScrSel = 4'b0000;

    // Table: apply one edge, then compare both read ports
    for (int k = 0; k < NVEC; k++) begin
      drive(vecs[k].reg_sel, vecs[k].scr_sel, vecs[k].fun_sel, vecs[k].data,
            vecs[k].a_sel, vecs[k].b_sel);
      @(posedge Clock); #1;
      check($sformatf("vec%0d_outa", k), OutA, vecs[k].exp_a);
      check($sformatf("vec%0d_outb", k), OutB, vecs[k].exp_b);
    end

    // Multi-select INC: old values visible before the edge, new ones after
    drive(4'b0010, 4'b1000, FS_INC, 32'h0, SEL_R3, SEL_S1);
    #1;
    check("multi_pre_r3", OutA, 32'h5);
    check("multi_pre_s1", OutB, 32'h9);
    @(posedge Clock); #1;
    check("multi_post_r3", OutA, 32'h6);
    check("multi_post_s1", OutB, 32'hA);
    idle();
    begin
      logic [WIDTH-1:0] exp_all [8];
      exp_all = '{32'h0, 32'h1, 32'h6, 32'h00007FFF, 32'hA, 32'h0, 32'h000000EF, 32'h0};
      for (int r = 0; r < 8; r++) begin
        OutASel = 3'(r); OutBSel = 3'(r);
        #1;
        check($sformatf("hold_a_%0d", r), OutA, exp_all[r]);
        check($sformatf("hold_b_%0d", r), OutB, exp_all[r]);
      end
    end

    // Load distinct values everywhere, then async reset mid-cycle
    for (int r = 0; r < 8; r++) begin
      if (r < 4) drive(4'(4'b1000 >> r), 4'b0000, FS_LOAD, 32'hA0000000 + 32'(r), 3'(r), 3'(r));
      else       drive(4'b0000, 4'(4'b1000 >> (r - 4)), FS_LOAD, 32'hA0000000 + 32'(r), 3'(r), 3'(r));
      @(posedge Clock); #1;
      check($sformatf("preload_%0d", r), OutA, 32'hA0000000 + 32'(r));
    end
    drive(4'b1111, 4'b1111, FS_INC, 32'h0, SEL_R1, SEL_S4);
    #2;
    Reset = 1'b0;
    #1;
    for (int r = 0; r < 8; r++) begin
      OutASel = 3'(r); OutBSel = 3'(7 - r);
      #0.1;
      check($sformatf("async_rst_a_%0d", r), OutA, 32'h0);
      check($sformatf("async_rst_b_%0d", r), OutB, 32'h0);
    end
    @(posedge Clock); #1;
    check("rst_held_r1", OutA, 32'h0);

    // First edge after release behaves normally
    @(negedge Clock);
    Reset = 1'b1; RegSel = 4'b0100; ScrSel = 4'b0000; FunSel = FS_DEC;
    OutASel = SEL_R2; OutBSel = SEL_R1;
    @(posedge Clock); #1;
    check("post_rst_dec_r2", OutA, 32'hFFFFFFFF);
    check("post_rst_r1", OutB, 32'h0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
